// File: rtl/mining_pkg.sv
// Shared types and constants for the mining job controller.
package mining_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned JOB_BYTES   = 14;
  localparam int unsigned BLOCK_BYTES = 12;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int unsigned TARGET_W    = 16;
  localparam int unsigned NONCE_W     = 32;
  localparam int unsigned STATUS_W    = 2;
  localparam int unsigned JOB_ID_W    = 8;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned CNT_W       = 16;

  localparam logic [STATUS_W-1:0] ST_FOUND   = 2'b00;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_CLR  = 3'd4
  } state_e;

  // Result record presented to the consumer.
  typedef struct packed {
    logic [NONCE_W-1:0]  nonce;
    logic [STATUS_W-1:0] status;
    logic [JOB_ID_W-1:0] job_id;
  } result_t;

endpackage

// File: rtl/mining_job_ctrl_if.sv
// Job byte stream, search-core and result signals of the job controller.
interface mining_job_ctrl_if;
  import mining_pkg::*;

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic [BLOCK_W-1:0]  block_out;
  logic [TARGET_W-1:0] target_out;
  logic                start;
  logic                finish;
  logic [NONCE_W-1:0]  nonce_in;
  logic                res_valid;
  logic                res_ready;
  logic [NONCE_W-1:0]  res_nonce;
  logic [STATUS_W-1:0] res_status;
  logic [JOB_ID_W-1:0] res_job_id;
  logic                busy;

  // Controller side.
  modport slave (
    input  in_valid, in_data, finish, nonce_in, res_ready,
    output in_ready, block_out, target_out, start, res_valid,
           res_nonce, res_status, res_job_id, busy
  );

  // Environment side: job source, search core and result consumer.
  modport master (
    output in_valid, in_data, finish, nonce_in, res_ready,
    input  in_ready, block_out, target_out, start, res_valid,
           res_nonce, res_status, res_job_id, busy
  );

endinterface

// File: rtl/job_byte_assembler.sv
// Collects the 14-byte job stream into the block and target registers.
module job_byte_assembler
  import mining_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_ready,
  input  logic [BYTE_W-1:0]   i_data,
  output logic [BLOCK_W-1:0]  o_block,
  output logic [TARGET_W-1:0] o_target,
  output logic                o_load_done_c
);

  logic [IDX_W-1:0]    r_idx;
  logic [BLOCK_W-1:0]  r_block;
  logic [TARGET_W-1:0] r_target;
  logic                w_xfer;
  logic                w_last;

  assign w_xfer        = i_valid & i_ready;
  assign w_last        = (r_idx == IDX_W'(JOB_BYTES - 1));
  assign o_load_done_c = w_xfer & w_last;
  assign o_block       = r_block;
  assign o_target      = r_target;

  // Write each accepted byte at the current index; index wraps after the last target byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_block  <= '0;
      r_target <= '0;
    end else if (w_xfer) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
        if (r_idx == IDX_W'(i)) r_block[i*BYTE_W +: BYTE_W] <= i_data;
      end
      if (r_idx == IDX_W'(BLOCK_BYTES))     r_target[15:8] <= i_data;
      if (r_idx == IDX_W'(BLOCK_BYTES + 1)) r_target[7:0]  <= i_data;
    end
  end

endmodule

// File: rtl/mining_job_ctrl.sv
// Job controller: loads a job, runs the search core, reports the result, then forces a start-low gap.
module mining_job_ctrl
  import mining_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  parameter int unsigned CLR_CYCLES     = 2
) (
  input logic               clk,
  input logic               reset,
  mining_job_ctrl_if.slave  bus
);

  state_e              r_state;
  logic                r_in_ready;
  logic                r_start;
  logic                r_busy;
  logic                r_res_valid;
  result_t             r_res;
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic [CNT_W-1:0]    r_clr_cnt;
  logic [JOB_ID_W-1:0] r_job_cnt;

  logic                w_xfer;
  logic                w_load_done_c;

  assign w_xfer = bus.in_valid & r_in_ready;

  job_byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (bus.in_valid),
    .i_ready       (r_in_ready),
    .i_data        (bus.in_data),
    .o_block       (bus.block_out),
    .o_target      (bus.target_out),
    .o_load_done_c (w_load_done_c)
  );

  assign bus.in_ready   = r_in_ready;
  assign bus.start      = r_start;
  assign bus.busy       = r_busy;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_nonce  = r_res.nonce;
  assign bus.res_status = r_res.status;
  assign bus.res_job_id = r_res.job_id;

  // Sequencing FSM with registered handshake, start and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_tmo_cnt   <= '0;
      r_clr_cnt   <= '0;
      r_job_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_load_done_c) begin
            r_state    <= S_RUN;
            r_start    <= 1'b1;
            r_in_ready <= 1'b0;
            r_tmo_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          // finish has priority over a timeout landing in the same cycle
          if (bus.finish) begin
            r_res       <= '{nonce: bus.nonce_in, status: ST_FOUND, job_id: r_job_cnt};
            r_res_valid <= 1'b1;
            r_start     <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_res       <= '{nonce: '0, status: ST_TIMEOUT, job_id: r_job_cnt};
            r_res_valid <= 1'b1;
            r_start     <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_job_cnt   <= r_job_cnt + JOB_ID_W'(1);
            r_clr_cnt   <= '0;
            r_state     <= S_CLR;
          end
        end
        S_CLR: begin
          if (r_clr_cnt == CNT_W'(CLR_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_start    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mining_job_ctrl.sv
// Self-checking bench for mining_job_ctrl with a job-level reference model.
module tb_mining_job_ctrl;

  localparam int T   = 10;
  localparam int CLR = 2;

  typedef logic [7:0] job_t [14];

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_id = 0;

  mining_job_ctrl_if bus ();

  mining_job_ctrl #(.TIMEOUT_CYCLES(T), .CLR_CYCLES(CLR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_job(output job_t b);
    for (int i = 0; i < 14; i++) b[i] = 8'($urandom);
  endtask

  // Stream a job, optionally with bubbles and a stale finish, then check RUN entry.
  task automatic send_job(input job_t b, input int gap_pct, input bit stale);
    logic [95:0] eb;
    logic [15:0] et;
    for (int i = 0; i < 12; i++) eb[8*i +: 8] = b[i];
    et = {b[12], b[13]};
    for (int i = 0; i < 14; i++) begin
      int gaps;
      gaps = ($urandom_range(99) < 32'(gap_pct)) ? int'($urandom_range(1, 3)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0; bus.in_data = 8'($urandom); bus.finish = stale;
        tick();
        n_chk++;
        if (bus.res_valid !== 1'b0 || bus.start !== 1'b0) begin
          n_fail++; $display("FAIL load_gap: res_valid=%b start=%b required 0 0", bus.res_valid, bus.start);
        end
      end
      n_chk++;
      if ({bus.in_ready, bus.start, bus.res_valid} !== 3'b100) begin
        n_fail++; $display("FAIL load_accept byte %0d: in_ready/start/res_valid=%b required 100", i, {bus.in_ready, bus.start, bus.res_valid});
      end
      bus.in_valid = 1'b1; bus.in_data = b[i]; bus.finish = stale;
      tick();
    end
    bus.in_valid = 1'b0; bus.finish = 1'b0;
    n_chk++;
    if ({bus.start, bus.in_ready, bus.busy} !== 3'b101) begin
      n_fail++; $display("FAIL run_entry: start/in_ready/busy=%b required 101", {bus.start, bus.in_ready, bus.busy});
    end
    n_chk++;
    if (bus.block_out !== eb) begin
      n_fail++; $display("FAIL block_out: got %h required %h", bus.block_out, eb);
    end
    n_chk++;
    if (bus.target_out !== et) begin
      n_fail++; $display("FAIL target_out: got %h required %h", bus.target_out, et);
    end
  endtask

  // Search phase: finish asserted d cycles into RUN (never if d >= T); check the result record.
  task automatic run_job(input int d, input logic [31:0] nonce,
                         output logic [1:0] est, output logic [31:0] enon);
    int n;
    n    = (d < T) ? d + 1 : T;
    est  = (d < T) ? 2'b00 : 2'b01;
    enon = (d < T) ? nonce : 32'h0;
    for (int i = 0; i < n; i++) begin
      if (i >= d) begin bus.finish = 1'b1; bus.nonce_in = nonce; end
      else        begin bus.finish = 1'b0; bus.nonce_in = $urandom; end
      n_chk++;
      if (bus.start !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_fail++; $display("FAIL run_cycle %0d: start=%b res_valid=%b required 1 0", i, bus.start, bus.res_valid);
      end
      tick();
    end
    bus.finish = 1'b0; bus.nonce_in = $urandom;
    n_chk++;
    if ({bus.res_valid, bus.start, bus.busy, bus.in_ready} !== 4'b1010) begin
      n_fail++; $display("FAIL done_entry: valid/start/busy/in_ready=%b required 1010", {bus.res_valid, bus.start, bus.busy, bus.in_ready});
    end
    n_chk++;
    if ({bus.res_nonce, bus.res_status, bus.res_job_id} !== {enon, est, 8'(exp_id)}) begin
      n_fail++; $display("FAIL result: nonce=%h status=%b id=%0d required %h %b %0d", bus.res_nonce, bus.res_status, bus.res_job_id, enon, est, exp_id);
    end
  endtask

  // Result handshake after wait_cyc backpressure cycles, then the start-low gap back to IDLE.
  task automatic finish_result(input int wait_cyc, input bit stale,
                               input logic [1:0] est, input logic [31:0] enon);
    bus.res_ready = 1'b0;
    for (int w = 0; w < wait_cyc; w++) begin
      tick();
      n_chk++;
      if ({bus.res_valid, bus.start, bus.res_nonce, bus.res_status, bus.res_job_id} !== {1'b1, 1'b0, enon, est, 8'(exp_id)}) begin
        n_fail++; $display("FAIL backpressure %0d: valid=%b nonce=%h status=%b id=%0d", w, bus.res_valid, bus.res_nonce, bus.res_status, bus.res_job_id);
      end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    exp_id = (exp_id + 1) % 256;
    for (int i = 0; i < CLR; i++) begin
      bus.finish = stale;
      n_chk++;
      if ({bus.start, bus.in_ready, bus.res_valid, bus.busy} !== 4'b0001) begin
        n_fail++; $display("FAIL clr_gap %0d: start/in_ready/valid/busy=%b required 0001", i, {bus.start, bus.in_ready, bus.res_valid, bus.busy});
      end
      tick();
    end
    n_chk++;
    if ({bus.start, bus.in_ready, bus.res_valid, bus.busy} !== 4'b0100) begin
      n_fail++; $display("FAIL idle_return: start/in_ready/valid/busy=%b required 0100", {bus.start, bus.in_ready, bus.res_valid, bus.busy});
    end
  endtask

  task automatic full_job(input job_t b, input int gap_pct, input bit stale,
                          input int d, input logic [31:0] nonce, input int wait_cyc);
    logic [1:0]  est;
    logic [31:0] enon;
    send_job(b, gap_pct, stale);
    run_job(d, nonce, est, enon);
    finish_result(wait_cyc, stale, est, enon);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_chk++;
    if ({bus.in_ready, bus.start, bus.res_valid, bus.busy, bus.block_out, bus.target_out,
         bus.res_nonce, bus.res_status, bus.res_job_id} !== {4'b1000, 96'h0, 16'h0, 32'h0, 2'b00, 8'h0}) begin
      n_fail++; $display("FAIL reset_values: ready/start/valid/busy=%b block=%h target=%h nonce=%h", {bus.in_ready, bus.start, bus.res_valid, bus.busy}, bus.block_out, bus.target_out, bus.res_nonce);
    end
    reset = 1'b0;
    exp_id = 0;
  endtask

  task automatic test_stream_found();
    job_t b;
    for (int i = 0; i < 12; i++) b[i] = 8'(i + 1);
    b[12] = 8'h00; b[13] = 8'h0A;
    full_job(b, 0, 1'b0, 3, 32'h00000305, 0);
  endtask

  task automatic test_timeout();
    job_t b;
    rand_job(b);
    full_job(b, 0, 1'b0, T + 5, 32'hDEADBEEF, 1);
  endtask

  task automatic test_backpressure();
    job_t b;
    rand_job(b);
    full_job(b, 0, 1'b0, 2, $urandom, 5);
  endtask

  task automatic test_bubbles_stale_finish();
    job_t b;
    rand_job(b);
    full_job(b, 60, 1'b1, 4, $urandom, 2);
  endtask

  task automatic test_finish_timeout_same();
    job_t b;
    rand_job(b);
    full_job(b, 0, 1'b0, T - 1, 32'hA5A5_0001, 0);
  endtask

  task automatic test_reset_mid_load();
    job_t b;
    rand_job(b);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.in_data = b[i];
      tick();
    end
    bus.in_valid = 1'b0;
    test_reset();
    rand_job(b);
    full_job(b, 0, 1'b0, 1, $urandom, 0);
  endtask

  task automatic test_reset_mid_run();
    job_t        b;
    logic [1:0]  est;
    logic [31:0] enon;
    rand_job(b);
    send_job(b, 0, 1'b0);
    tick(); tick(); tick();
    test_reset();
    rand_job(b);
    send_job(b, 20, 1'b0);
    run_job(0, $urandom, est, enon);
    finish_result(1, 1'b0, est, enon);
  endtask

  task automatic test_random();
    job_t b;
    for (int j = 0; j < 20; j++) begin
      rand_job(b);
      full_job(b, 30, 1'($urandom_range(1)), int'($urandom_range(0, T + 2)),
               $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h0;
    bus.finish   = 1'b0;
    bus.nonce_in = 32'h0;
    bus.res_ready = 1'b0;
    test_reset();
    test_stream_found();
    test_timeout();
    test_backpressure();
    test_bubbles_stale_finish();
    test_finish_timeout_same();
    test_reset_mid_load();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mining_job_ctrl.md
Name: mining_job_ctrl

Overview:
- Upstream job controller for the nonce-search core. It is the stage that drives the core's block bytes, target and start, and consumes its finish flag and nonce bytes.
- Receives a mining job as a byte stream over a valid/ready interface and assembles the 12 block bytes plus the 16-bit target.
- Holds start high to the search core until finish or a cycle timeout, then captures the nonce and presents a result record over a second valid/ready interface.
- Forces a start-low gap between jobs so the core clears its internal counters.

Parameters:
- TIMEOUT_CYCLES, 60000: maximum cycles in RUN before the job is abandoned; legal range 2..65535.
- CLR_CYCLES, 2: cycles start is held low after a result transfer; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  job byte valid
- in_data  in  8  job byte
- in_ready  out  1  controller can accept a job byte
- block_out  out  96  assembled block; block byte i on bits [8i+7:8i], drives core block0..block11
- target_out  out  16  search target to the core
- start  out  1  core start; held high for the whole search
- finish  in  1  core finish flag, level
- nonce_in  in  32  core nonce0..nonce3; nonce0 on bits [7:0]
- res_valid  out  1  result record valid
- res_ready  in  1  result consumer ready
- res_nonce  out  32  captured nonce
- res_status  out  2  2'b00 found, 2'b01 timeout
- res_job_id  out  8  sequence number of the job
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state IDLE; in_ready 1; start 0; res_valid 0.
  - block_out, target_out, res_nonce, res_status, res_job_id all 0.
  - byte index 0; timeout counter 0; job counter 0.
- Reset in any state discards a partial job or a pending result. start drops the cycle after reset is sampled.
- States: IDLE, LOAD, RUN, DONE, CLR.
- Byte transfer occurs when in_valid && in_ready. in_ready is 1 only in IDLE and LOAD.
- Byte index k, 0..13:
  - k 0..11 writes block_out byte k.
  - k 12 writes target_out[15:8].
  - k 13 writes target_out[7:0].
- IDLE: a transfer writes byte 0 and moves to LOAD with index 1. in_valid low leaves the state unchanged.
- LOAD: each transfer writes at the index and increments it. Bubbles (in_valid low) are allowed with no timeout.
- LOAD to RUN: if byte 13 transfers in cycle t, then at t+1 the state is RUN, start is 1, in_ready is 0, and the timeout counter is 0.
- RUN: the timeout counter increments every cycle.
  - If finish is sampled 1 in cycle f: at f+1 res_nonce = nonce_in sampled at f, res_status 00, res_valid 1, start 0, state DONE.
  - Else if the counter equals TIMEOUT_CYCLES-1: at the next cycle res_nonce 0, res_status 01, res_valid 1, start 0, state DONE.
  - If finish and timeout occur in the same cycle, finish wins.
- DONE:
  - res_valid stays high and res_nonce, res_status, res_job_id stay stable until res_ready. No retraction.
  - A transfer occurs when res_valid && res_ready. On that cycle the job counter increments (8-bit, wraps FF to 00) and the state moves to CLR.
  - res_job_id reports the counter value before the increment.
- CLR: start 0 and in_ready 0 for exactly CLR_CYCLES cycles, then IDLE.
- block_out and target_out are held from entry to RUN until the first byte of the next job overwrites them. The core sees stable data for the whole search.
- finish is ignored outside RUN. A stale finish in CLR or IDLE has no effect.
- No combinational path exists from inputs to outputs. All outputs are registered or decoded from registered state.

Decomposition:
- Shared package mining_pkg holds:
  - state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, CLR=4);
  - status codes ST_FOUND=2'b00 and ST_TIMEOUT=2'b01;
  - JOB_BYTES=14 and BLOCK_BYTES=12.
- One natural sub-module: job_byte_assembler, holding the byte index and the block/target registers, with a load-done pulse to the FSM.
- The FSM, timeout counter and result register stay in the top.

Test Plan:
- Streaming load and found: send bytes 0x01..0x0C, then 0x00, 0x0A with in_valid held high.
  - Required: block_out == 96'h0C0B0A090807060504030201 and target_out == 16'h000A.
  - start rises the cycle after byte 13.
  - Assert finish with nonce_in 32'h00000305. The next cycle gives res_valid 1, res_status 00, res_nonce 32'h00000305, res_job_id 0.
- Timeout with TIMEOUT_CYCLES=10 and finish held 0.
  - Required: exactly 10 RUN cycles with start high, then res_status 01, res_nonce 0, start 0.
- Backpressure: hold res_ready 0 for 5 cycles in DONE.
  - Required: res_valid and all fields stable throughout.
  - Assert res_ready. Then start stays low CLR_CYCLES cycles, in_ready returns to 1, and the next result carries res_job_id 1.
- Input bubbles and stale finish: insert in_valid gaps mid-load and drive finish 1 during LOAD and CLR.
  - Required: correct assembly and no early result.
  - finish and timeout in the same cycle yields status 00.
- Reset mid-operation: assert reset in LOAD after 7 bytes, and separately in RUN.
  - Required: all outputs return to reset values the next cycle.
  - A following full job loads from byte index 0 correctly.
